// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sqrt operand sequencer.
// Holds the default widths, the job FSM states and a constant-width helper.
package sqrt_pkg;

  localparam int NUM_W_DEF = 7;
  localparam int RES_W_DEF = 4;
  localparam int RES_ERR   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    OUT     = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sqrt_job_feeder_if.sv
// Bundles the operand input, sqrt-core and result output handshakes of the feeder.
// slave is the feeder's view; master is the surrounding environment's view.
interface sqrt_job_feeder_if #(
  parameter int NUM_W = 7,
  parameter int RES_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] in_num;
  logic             core_start;
  logic [NUM_W-1:0] core_num;
  logic             core_ready;
  logic [RES_W-1:0] core_result;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] out_num;
  logic [RES_W-1:0] out_result;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_num, core_ready, core_result, out_ready,
    output in_ready, core_start, core_num, out_valid, out_num, out_result, out_err, busy
  );

  modport master (
    output in_valid, in_num, core_ready, core_result, out_ready,
    input  in_ready, core_start, core_num, out_valid, out_num, out_result, out_err, busy
  );
endinterface

// File: rtl/sqrt_op_fifo.sv
// Operand FIFO, DEPTH x NUM_W, with asynchronous clear of the pointers.
// Head entry is visible combinationally; full/empty use an extra pointer bit.
module sqrt_op_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_W = 7
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic [NUM_W-1:0] push_data,
  input  logic             pop,
  output logic [NUM_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [NUM_W-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of the clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sqrt_job_feeder.sv
// Sequences buffered operands into the sqrt core one job at a time and hands
// each captured result downstream; a watchdog turns a silent core into an error result.
module sqrt_job_feeder
  import sqrt_pkg::*;
#(
  parameter int NUM_W   = NUM_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             clear,
  sqrt_job_feeder_if.slave bus
);

  localparam int                CNT_W    = clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] core_num_q;
  logic [NUM_W-1:0] out_num_q;
  logic [RES_W-1:0] out_res_q;
  logic             out_err_q;
  logic [NUM_W-1:0] head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             cap_ok;
  logic             cap_err;

  sqrt_op_fifo #(
    .DEPTH (DEPTH),
    .NUM_W (NUM_W)
  ) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push      (bus.in_valid),
    .push_data (bus.in_num),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    cap_ok   = 1'b0;
    cap_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // A late ready wins over the watchdog in the same cycle.
        if (bus.core_ready) begin
          cap_ok   = 1'b1;
          state_nx = RELEASE;
        end else if (cnt == CNT_LAST) begin
          cap_err  = 1'b1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        // Wait out a ready still held from this job so the next one cannot see it.
        if (!bus.core_ready) state_nx = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt        <= '0;
      core_num_q <= '0;
      out_num_q  <= '0;
      out_res_q  <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (pop) begin
        core_num_q <= head;
        cnt        <= '0;
      end else if (state == ISSUE && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_ok) begin
        out_res_q <= bus.core_result;
        out_num_q <= core_num_q;
        out_err_q <= 1'b0;
      end else if (cap_err) begin
        out_res_q <= RES_W'(RES_ERR);
        out_num_q <= core_num_q;
        out_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.core_start = (state == ISSUE);
  assign bus.core_num   = core_num_q;
  assign bus.out_valid  = (state == OUT);
  assign bus.out_num    = out_num_q;
  assign bus.out_result = out_res_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_sqrt_job_feeder.sv
// Randomised bench for sqrt_job_feeder: behavioural sqrt core, expected-result
// queue built from accepted operands, and directed phases for the corner cases.
module tb_sqrt_job_feeder;
  import sqrt_pkg::*;

  localparam int NUM_W   = 7;
  localparam int RES_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  sqrt_job_feeder_if #(.NUM_W(NUM_W), .RES_W(RES_W)) bus ();

  sqrt_job_feeder #(
    .NUM_W   (NUM_W),
    .RES_W   (RES_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    int num;
    int err;
  } job_t;

  job_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   core_dead = 1'b0;
  int   lat_min = 0;
  int   lat_max = 3;
  int   hold_max = 2;
  bit   rnd_bp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Behavioural core: answers after a random latency, holds ready a few cycles past start.
  initial begin
    int  cnt, lat, hcnt, hold;
    bit  started;
    cnt = 0; lat = 0; hcnt = 0; hold = 0; started = 1'b0;
    bus.core_ready  = 1'b0;
    bus.core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (clear || core_dead) begin
        bus.core_ready = 1'b0;
        started = 1'b0;
        cnt = 0;
      end else if (bus.core_start && !bus.core_ready) begin
        if (!started) begin
          started = 1'b1;
          cnt = 0;
          lat = int'($urandom_range(lat_max, lat_min));
        end
        if (cnt >= lat) begin
          bus.core_ready  = 1'b1;
          bus.core_result = RES_W'(isqrt(int'(bus.core_num)));
          hcnt = 0;
          hold = int'($urandom_range(hold_max, 0));
        end else begin
          cnt++;
        end
      end else if (!bus.core_start && bus.core_ready) begin
        if (hcnt >= hold) begin
          bus.core_ready = 1'b0;
          started = 1'b0;
        end else begin
          hcnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.out_ready = $urandom_range(1, 0) != 0;
    end
  end

  // Output monitor: each handshake must match the oldest accepted operand.
  initial begin
    bit             rel_pend;
    bit             prev_start;
    logic [NUM_W-1:0] prev_num;
    job_t           j;
    rel_pend = 1'b0;
    prev_start = 1'b0;
    prev_num = '0;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
          end else begin
            j = exp_q.pop_front();
            chk("out_num", 32'(bus.out_num), j.num);
            chk("out_result", 32'(bus.out_result), j.err != 0 ? 0 : isqrt(j.num));
            chk("out_err", 32'(bus.out_err), j.err);
          end
        end
        if (rel_pend) chk("start_drop", 32'(bus.core_start), 32'd0);
        if (prev_start && bus.core_start) chk("core_num_stable", 32'(bus.core_num), 32'(prev_num));
      end
      rel_pend   = bus.core_start && bus.core_ready && !clear;
      prev_start = bus.core_start && !clear;
      prev_num   = bus.core_num;
    end
  end

  task automatic push(input int num);
    int n;
    bit done;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_num   = NUM_W'(num);
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{num: num, err: int'(core_dead)});
        done = 1'b1;
      end
      n++;
    end
    if (!done) chk("push_accept", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q", exp_q.size(), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!bus.core_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(bus.core_start), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic [NUM_W-1:0] h_num;
    logic [RES_W-1:0] h_res;
    logic             h_err;

    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.out_ready = 1'b1;
    clear = 1'b1;
    #1;
    chk("rst_core_start", 32'(bus.core_start), 32'd0);
    chk("rst_core_num", 32'(bus.core_num), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_num", 32'(bus.out_num), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;

    push(25);
    wait_drain(300);

    push(2);
    push(0);
    push(127);
    wait_drain(300);

    // Slow core keeps the first job in ISSUE while the FIFO fills behind it.
    lat_min = 40;
    lat_max = 40;
    push(10);
    wait_start(50);
    push(11);
    push(12);
    push(13);
    push(14);
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_num   = NUM_W'(99);
    repeat (5) begin
      @(negedge clk);
      chk("full_block", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat_min = 0;
    lat_max = 3;
    wait_drain(1000);

    bus.out_ready = 1'b0;
    push(50);
    push(60);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    h_num = bus.out_num;
    h_res = bus.out_result;
    h_err = bus.out_err;
    chk("bp_first_num", 32'(h_num), 32'd50);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_num_hold", 32'(bus.out_num), 32'(h_num));
      chk("bp_res_hold", 32'(bus.out_result), 32'(h_res));
      chk("bp_err_hold", 32'(bus.out_err), 32'(h_err));
      chk("bp_no_issue", 32'(bus.core_start), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain(300);

    core_dead = 1'b1;
    push(9);
    push(20);
    wait_start(50);
    n = 0;
    while (bus.core_start && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, TIMEOUT);
    wait_drain(500);
    core_dead = 1'b0;

    lat_min = 0;
    lat_max = 5;
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(int'($urandom_range(127, 0)));
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain(2000);

    lat_min = 40;
    lat_max = 40;
    push(70);
    wait_start(50);
    push(71);
    push(72);
    @(negedge clk);
    #2;
    clear = 1'b1;
    exp_q.delete();
    #1;
    chk("clr_core_start", 32'(bus.core_start), 32'd0);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    lat_min = 0;
    lat_max = 3;
    repeat (100) @(negedge clk);
    chk("clr_idle_busy", 32'(bus.busy), 32'd0);
    chk("clr_idle_start", 32'(bus.core_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_job_feeder.md
Name: sqrt_job_feeder

Overview:
Operand sequencer that sits directly in front of the sqrt_Top core. It buffers incoming 7-bit operands in a small FIFO and drives the core's start/num inputs one job at a time. It captures each core result when the core signals ready and presents it downstream with a valid/ready handshake. A watchdog flags jobs whose core never reports ready.

Parameters:
NUM_W, 7, operand width (matches core num)
RES_W, 4, result width, ceil(NUM_W/2)
DEPTH, 4, operand FIFO depth (power of 2, >=2)
TIMEOUT, 64, max cycles in ISSUE before a job is declared failed

Ports:
clk  in  1  rising-edge clock
clear  in  1  asynchronous, active-high reset
in_valid  in  1  operand offered
in_ready  out  1  FIFO can accept (= !full)
in_num  in  NUM_W  operand
core_start  out  1  start to sqrt core, held high for the job
core_num  out  NUM_W  operand to core, stable while core_start=1
core_ready  in  1  core result valid
core_result  in  RES_W  core result
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_num  out  NUM_W  operand belonging to out_result
out_result  out  RES_W  floor(sqrt(out_num)); 0 on error
out_err  out  1  job timed out
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (clear=1, async): FIFO empty, state IDLE, timeout counter 0.
- Output reset values: core_start=0, core_num=0, out_valid=0, out_num=0, out_result=0, out_err=0, busy=0, in_ready=1.
- clear mid-job: core_start drops immediately; queued operands and any held result are discarded.
- FIFO:
  - Push on in_valid&in_ready.
  - Pop only in IDLE when non-empty.
  - in_ready depends on full only; no pass-through when full, even in a pop cycle.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- FSM states are IDLE, ISSUE, RELEASE, OUT.
- IDLE:
  - If FIFO non-empty, pop into core_num, set core_start=1, clear counter, go ISSUE.
  - Transition happens on the edge after the operand is visible at the FIFO head; an operand pushed at edge t into an empty FIFO gives core_start=1 after edge t+1.
- ISSUE:
  - core_start=1, counter increments each cycle.
  - If core_ready=1: capture core_result→out_result, core_num→out_num, out_err=0; core_start=0; go RELEASE.
  - Else if counter==TIMEOUT-1: out_result=0, out_num=core_num, out_err=1; core_start=0; go RELEASE.
  - core_ready takes priority over timeout in the same cycle.
- RELEASE:
  - core_start=0 for at least one cycle.
  - Stay until core_ready=0, then go OUT.
  - This prevents a stale ready from being captured for the next job.
- OUT:
  - out_valid=1; out_num/out_result/out_err held stable.
  - On out_valid&out_ready: out_valid=0, go IDLE.
  - The next job's core_start rises one cycle later.
- While the FSM is busy, the FIFO keeps accepting operands until full.
- Widths: no arithmetic on operands. Counter width is clog2(TIMEOUT)+1 and saturates, never wraps.
- core_result is passed through unmodified.

Decomposition:
- Package sqrt_pkg:
  - NUM_W, RES_W defaults.
  - State enum {IDLE, ISSUE, RELEASE, OUT}.
  - RES_ERR=0 constant.
  - clog2 helper.
- One sub-module, sqrt_op_fifo: parameterised DEPTH x NUM_W synchronous FIFO with push/pop/full/empty and async clear. The FSM and watchdog stay in sqrt_job_feeder.

Test Plan:
- Single job, core = sqrt_Top: push 25 → out_num=25, out_result=5, out_err=0; core_start high exactly until core_ready seen.
- Floor cases: push 2, 0, 127 sequentially → results 1, 0, 11 in order, one out_valid pulse each, out_ready tied 1.
- FIFO full: with the FSM stuck in ISSUE, push 4 operands → in_ready=0 after the 4th; a 5th in_valid is not accepted; all 4 results later emerge in push order.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_* stable, core_start stays 0, no new job issued until the handshake.
- Timeout: core_ready tied 0, push 9 → after TIMEOUT (64) cycles in ISSUE, out_valid=1, out_err=1, out_result=0, out_num=9; the next queued job then proceeds.
- clear mid-ISSUE with 2 operands queued → same cycle core_start=0, out_valid=0, busy=0, in_ready=1; no result appears afterwards.
